// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: single-cycle hits, blocking line refill from
// a memory port that returns WORDS beats in ascending order.
module icache_dm #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] instr,
  input  logic              flush,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W - OFF_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
  } faddr_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] FILL = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]        state;
  faddr_t            ia, ra;
  logic [OFF_W-1:0]  k;
  logic              flush_pend, hit_q;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES*WORDS];

  logic accept, hit, beat, last, unused_bits;

  // Byte-select bits never reach the arrays.
  assign ia          = faddr_t'(req_addr[ADDR_W-1:2]);
  assign unused_bits = ^req_addr[1:0];

  assign req_ready = (state == IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign hit       = valid[ia.idx] && (tag_mem[ia.idx] == ia.tag);
  assign beat      = (state == FILL) && mem_rsp_valid;
  assign last      = (k == OFF_W'(WORDS-1));

  // The array is never written while a hit response is pending, so one read
  // port on the registered address serves both hit and refill responses.
  assign rsp_valid     = hit_q || (state == RESP);
  assign instr         = data_mem[{ra.idx, ra.off}];
  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = mem_req_valid ? {ra.tag, ra.idx, {(OFF_W+2){1'b0}}} : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      k          <= '0;
      flush_pend <= 1'b0;
      hit_q      <= 1'b0;
      ra         <= '0;
    end else begin
      hit_q <= accept && hit;
      case (state)
        IDLE: begin
          if (flush) valid <= '0;
          else if (accept) begin
            ra <= ia;
            if (!hit) state <= REQ;
          end
        end
        REQ: begin
          if (flush) flush_pend <= 1'b1;
          k <= '0;
          if (mem_req_ready) state <= FILL;
        end
        FILL: begin
          if (flush) flush_pend <= 1'b1;
          if (beat) begin
            k <= k + 1'b1;
            if (last) begin
              state <= RESP;
              if (!(flush_pend || flush)) valid[ra.idx] <= 1'b1;
            end
          end
        end
        RESP: begin
          // A flush seen during the refill takes effect only once the response is out.
          state <= IDLE;
          if (flush_pend || flush) valid <= '0;
          flush_pend <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && beat) begin
      data_mem[{ra.idx, k}] <= mem_rsp_data;
      if (last) tag_mem[ra.idx] <= ra.tag;
    end
  end
endmodule

// File: tb/tb_icache_dm.sv
// Randomized bench for icache_dm against a line-level cache model with a
// deterministic backing memory.
module tb_icache_dm;
  localparam int LINES = 16;
  localparam int WORDS = 4;

  logic        clock = 0, reset = 1, req_valid = 0, flush = 0;
  logic        mem_req_ready = 0, mem_rsp_valid = 0;
  logic [31:0] req_addr = 0, mem_rsp_data = 0;
  logic        req_ready, rsp_valid, mem_req_valid;
  logic [31:0] instr, mem_req_addr;

  icache_dm #(.ADDR_W(32), .DATA_W(32), .LINES(LINES), .WORDS(WORDS)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .instr(instr), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0;
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  logic [31:0] m_data  [LINES][WORDS];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] la, input int k);
    logic [15:0] kk;
    kk = 16'(k);
    return {la[15:0] ^ 16'hC3A5, kk * 16'h1111};
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[7:4]] && (m_tag[a[7:4]] == 32'(a[31:8]));
  endfunction

  task automatic model_inval();
    for (int i = 0; i < LINES; i++) m_valid[i] = 0;
  endtask

  // mode 0: plain, 1: flush with 2nd beat, 2: reset after 2nd beat (misses only).
  // stall < 0 picks a random request backpressure of 0..5 cycles.
  task automatic fetch(input logic [31:0] a, input int mode, input int stall);
    logic [31:0] la;
    int ix, st, gap;
    bit hit;
    la  = {a[31:4], 4'h0};
    ix  = int'(a[7:4]);
    hit = model_hit(a);
    st  = (stall < 0) ? int'($urandom_range(0, 5)) : stall;
    @(negedge clock);
    chk("idle_req_ready", req_ready, 1);
    req_valid = 1; req_addr = a;
    @(negedge clock);
    req_valid = 0; req_addr = $urandom;
    if (hit) begin
      chk("hit_rsp_valid", rsp_valid, 1);
      chk("hit_instr", instr, m_data[ix][a[3:2]]);
      chk("hit_no_mem_req", mem_req_valid, 0);
      return;
    end
    chk("miss_no_rsp", rsp_valid, 0);
    chk("miss_mem_req_valid", mem_req_valid, 1);
    chk("miss_mem_req_addr", mem_req_addr, la);
    repeat (st) begin
      @(negedge clock);
      chk("bp_mem_req_valid", mem_req_valid, 1);
      chk("bp_mem_req_addr", mem_req_addr, la);
      chk("bp_req_ready", req_ready, 0);
    end
    mem_req_ready = 1;
    @(negedge clock);
    mem_req_ready = 0;
    chk("fill_mem_req_dropped", mem_req_valid, 0);
    for (int k = 0; k < WORDS; k++) begin
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin
        mem_rsp_valid = 0; mem_rsp_data = $urandom;
        @(negedge clock);
        chk("fill_no_rsp", rsp_valid, 0);
      end
      mem_rsp_valid = 1; mem_rsp_data = memw(la, k);
      if (mode == 1 && k == 1) flush = 1;
      @(negedge clock);
      mem_rsp_valid = 0; flush = 0;
      if (mode == 2 && k == 1) begin
        reset = 1; mem_rsp_valid = 1; mem_rsp_data = $urandom;
        @(negedge clock);
        reset = 0;
        chk("rst_no_rsp", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_req_addr", mem_req_addr, 0);
        repeat (2) begin
          mem_rsp_data = $urandom;
          @(negedge clock);
          chk("rst_stray_beat", rsp_valid, 0);
        end
        mem_rsp_valid = 0;
        model_inval();
        return;
      end
    end
    chk("fill_rsp_valid", rsp_valid, 1);
    chk("fill_instr", instr, memw(la, int'(a[3:2])));
    chk("fill_no_mem_req", mem_req_valid, 0);
    if (mode == 1) model_inval();
    else begin
      m_valid[ix] = 1;
      m_tag[ix]   = 32'(a[31:8]);
      for (int k = 0; k < WORDS; k++) m_data[ix][k] = memw(la, k);
    end
    @(negedge clock);
    chk("rsp_one_cycle", rsp_valid, 0);
  endtask

  // Back-to-back requests, one per cycle; all are expected to hit.
  task automatic stream(input logic [31:0] base);
    logic [31:0] prev;
    prev = base;
    for (int i = 0; i <= WORDS; i++) begin
      @(negedge clock);
      if (i > 0) begin
        chk("stream_rsp_valid", rsp_valid, 1);
        chk("stream_instr", instr, m_data[prev[7:4]][prev[3:2]]);
        chk("stream_no_mem_req", mem_req_valid, 0);
      end
      prev = base + 32'(4 * i);
      req_valid = (i < WORDS); req_addr = prev;
    end
    req_valid = 0;
  endtask

  task automatic flush_idle(input logic [31:0] a);
    @(negedge clock);
    flush = 1; req_valid = 1; req_addr = a;
    #1 chk("flush_req_ready", req_ready, 0);
    @(negedge clock);
    flush = 0; req_valid = 0;
    chk("flush_no_rsp", rsp_valid, 0);
    chk("flush_no_mem_req", mem_req_valid, 0);
    model_inval();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int r;
    model_inval();
    repeat (2) @(negedge clock);
    reset = 0;
    #1;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_mem_req_valid", mem_req_valid, 0);
    chk("reset_mem_req_addr", mem_req_addr, 0);

    fetch(32'h48, 0, 0);          // cold miss, refill of line 0x40
    stream(32'h40);               // four consecutive hits
    fetch(32'h440, 0, 0);         // conflict on the same index
    fetch(32'h48, 0, 0);          // misses again
    fetch(32'h84C, 0, 5);         // request backpressure
    fetch(32'h100, 1, 0);         // flush during refill
    fetch(32'h104, 0, 0);         // same line misses
    fetch(32'h200, 2, 0);         // reset mid-refill
    fetch(32'h200, 0, 0);         // same address misses
    fetch(32'h204, 0, -1);        // hit
    flush_idle(32'h204);
    fetch(32'h204, 0, -1);        // miss after flush

    for (int n = 0; n < 200; n++) begin
      a = {22'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'h0,
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      r = int'($urandom_range(0, 99));
      if (r < 6) flush_idle(a);
      else if (r < 14) fetch(a, 1, -1);
      else if (r < 20) fetch(a, 2, -1);
      else fetch(a, 0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, the instruction/word width.
REQ-003 SHALL have parameter LINES, default 16, the number of lines, a power of 2 and at least 2.
REQ-004 SHALL have parameter WORDS, default 4, the words per line, a power of 2 and at least 2.
REQ-005 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-007 SHALL have port req_valid, input, 1, the CPU fetch request.
REQ-008 SHALL have port req_addr, input, ADDR_W, the fetch byte address; bits [1:0] are ignored.
REQ-009 SHALL have port req_ready, output, 1, meaning the cache accepts a request this cycle.
REQ-010 SHALL have port rsp_valid, output, 1, meaning instr is valid this cycle.
REQ-011 SHALL have port instr, output, DATA_W, the fetched instruction.
REQ-012 SHALL have port flush, input, 1, a one-cycle pulse that invalidates all lines.
REQ-013 SHALL have port mem_req_valid, output, 1, the line-refill request.
REQ-014 SHALL have port mem_req_addr, output, ADDR_W, the line-aligned refill byte address.
REQ-015 SHALL have port mem_req_ready, input, 1, the memory's acceptance of the refill request.
REQ-016 SHALL have port mem_rsp_valid, input, 1, a refill data beat.
REQ-017 SHALL have port mem_rsp_data, input, DATA_W, the refill word, delivered in ascending word order.

Function
REQ-018 SHALL split req_addr into these fields: [1:0] byte (ignored); next log2(WORDS) bits word offset; next log2(LINES) bits index; remaining upper bits tag.
REQ-019 SHALL implement a direct-mapped store of LINES x WORDS data words, with one tag and one valid bit per line.
REQ-020 SHALL implement FSM states IDLE, REQ, FILL, RESP.
REQ-021 SHALL drive req_ready=1 only in IDLE with no flush this cycle; a request is accepted on req_valid && req_ready.
REQ-022 SHALL register the address of an accepted request; a request not accepted has no effect.
REQ-023 On a hit, SHALL assert rsp_valid with the addressed word in the next cycle (1-cycle latency), and stay in IDLE so a back-to-back request is accepted every cycle.
REQ-024 On a miss, SHALL move IDLE->REQ, drive mem_req_valid=1 and mem_req_addr={tag,index,0...}, and hold both stable until mem_req_ready.
REQ-025 SHALL move REQ->FILL on mem_req_valid && mem_req_ready.
REQ-026 In FILL, SHALL write each mem_rsp_valid beat to word counter k (0..WORDS-1), increment k, and ignore mem_rsp_valid outside FILL.
REQ-027 On the final beat (k==WORDS-1), SHALL write that line's tag and set its valid bit (unless REQ-031 applies), then enter RESP.
REQ-028 In RESP, SHALL assert rsp_valid for one cycle with the requested word, then return to IDLE.
REQ-029 SHALL hold rsp_valid=0 in all other cycles; instr is don't-care when rsp_valid=0.
REQ-030 Flush in IDLE SHALL clear all valid bits at the next edge; a same-cycle req_valid is not accepted.
REQ-031 Flush during REQ/FILL/RESP SHALL complete the refill and RESP response, leave the filled line invalid, and clear all valid bits at the return to IDLE.
REQ-032 SHALL treat tag equality with the valid bit clear as a miss.

Reset
REQ-033 Reset SHALL force state IDLE, clear all valid bits, k=0, and a pending flush to 0, with no memory response pending.
REQ-034 Outputs in the cycle after reset SHALL be req_ready=1, rsp_valid=0, mem_req_valid=0, and mem_req_addr=0.
REQ-035 Reset mid-refill SHALL abandon the refill, drop the remaining beats, leave the line invalid, and produce no rsp_valid.
REQ-036 Data array contents SHALL NOT require reset.

Verification
REQ-037 A cold miss SHALL behave as follows: req 0x0000_0048, mem_req_ready held 1, beats A0..A3 -> mem_req_addr=0x40, rsp_valid with instr=A2 exactly 1 cycle after the 4th beat.
REQ-038 A hit stream SHALL behave as follows: after REQ-037, reqs 0x40,0x44,0x48,0x4C on consecutive cycles -> rsp_valid on 4 consecutive cycles with A0..A3 and no mem_req_valid.
REQ-039 A conflict SHALL behave as follows: req 0x440 (same index, tag differs) -> refill; then 0x48 misses again.
REQ-040 Flush SHALL behave as follows: a flush pulse during the 2nd beat of a refill -> response still delivered; the next req to the same line misses.
REQ-041 Backpressure SHALL behave as follows: mem_req_ready low for 5 cycles -> mem_req_valid and mem_req_addr stable, req_ready=0 throughout.
REQ-042 Reset SHALL behave as follows: assert reset after the 2nd beat -> no rsp_valid, req_ready=1 the next cycle, and the same address misses.
